// File: rtl/id_ex_mem_regs_pkg.sv
// Shared widths, constants and helpers for the IF/ID and ID/EX pipeline
// registers and the data-memory array.
package id_ex_mem_regs_pkg;

  localparam int XLEN     = 64;
  localparam int ILEN     = 32;
  localparam int ALU_OP_W = 17;

  // Canonical bubble instruction: addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  // One-hot access-width codes
  localparam logic [3:0] MASK_BYTE  = 4'b0001;
  localparam logic [3:0] MASK_HALF  = 4'b0010;
  localparam logic [3:0] MASK_WORD  = 4'b0100;
  localparam logic [3:0] MASK_DWORD = 4'b1000;

  // Load-extension codes; 1x is reserved and behaves as zero-extend
  localparam logic [1:0] SEL_ZEXT = 2'b00;
  localparam logic [1:0] SEL_SEXT = 2'b01;

  // Data-memory geometry: 1024 x 64-bit words at a fixed base
  localparam int              DMEM_WORDS = 1024;
  localparam int              DMEM_IDX_W = 10;
  localparam logic [XLEN-1:0] DMEM_BASE  = 64'h0000_0000_8000_0000;
  localparam logic [XLEN-1:0] DMEM_BYTES = 64'h0000_0000_0000_2000;

  // ID/EX bundle, kept as one packed struct so bubble/reset is a single assignment
  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [ILEN-1:0]     inst;
    logic [ALU_OP_W-1:0] alu_op;
    logic [3:0]          sel_alures;
    logic [XLEN-1:0]     alu_src1;
    logic [XLEN-1:0]     alu_src2;
    logic [1:0]          sel_rfres;
    logic                rf_we;
    logic [4:0]          rf_waddr;
    logic [XLEN-1:0]     rf_rdata2;
    logic                mem_ena;
    logic                mem_wen;
    logic [3:0]          mem_mask;
    logic [1:0]          sel_memdata;
    logic                load;
    logic                sys;
  } ex_bundle_t;

  // Bubble content: everything zero except the instruction, which is NOP
  function automatic ex_bundle_t ex_bubble();
    ex_bundle_t b;
    b      = '0;
    b.inst = NOP;
    return b;
  endfunction

  // True when the width mask is exactly one of the four legal codes
  function automatic logic is_onehot_mask(input logic [3:0] m);
    return (m == MASK_BYTE) || (m == MASK_HALF) ||
           (m == MASK_WORD) || (m == MASK_DWORD);
  endfunction

  // Byte-lane pattern (aligned at lane 0) for a width mask
  function automatic logic [7:0] width_lanes(input logic [3:0] m);
    logic [7:0] l;
    l = 8'h00;
    case (m)
      MASK_BYTE:  l = 8'h01;
      MASK_HALF:  l = 8'h03;
      MASK_WORD:  l = 8'h0F;
      MASK_DWORD: l = 8'hFF;
      default:    l = 8'h00;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/id_ex_mem_regs_dmem.sv
// Data-memory array: 1024 x 64-bit storage with byte-lane writes and a
// combinational read that extracts, right-aligns and extends the addressed field.
module dmem_array
  import id_ex_mem_regs_pkg::*;
(
  input  logic            clk,
  input  logic            i_ena,
  input  logic            i_wen,
  input  logic [3:0]      i_mask,
  input  logic [1:0]      i_sel,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_rdata
);

  logic [XLEN-1:0]       r_mem [DMEM_WORDS];

  logic [XLEN-1:0]       w_off;
  logic                  w_in_win;
  logic                  w_mask_ok;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic                  w_sign;
  logic [DMEM_IDX_W-1:0] w_idx;
  logic [2:0]            w_byte;
  logic [5:0]            w_shamt;
  logic [7:0]            w_lanes;
  logic [XLEN-1:0]       w_wdata_sh;
  logic [XLEN-1:0]       w_word_sh;
  logic [XLEN-1:0]       w_rd_ext;

  // Unsigned subtraction makes addresses below the base wrap high, so one compare covers both ends
  assign w_off      = i_addr - DMEM_BASE;
  assign w_in_win   = (w_off < DMEM_BYTES);
  assign w_idx      = w_off[12:3];
  assign w_byte     = w_off[2:0];
  assign w_shamt    = {w_byte, 3'b000};
  assign w_mask_ok  = is_onehot_mask(i_mask);
  assign w_wr_en    = i_ena & i_wen & w_in_win & w_mask_ok;
  assign w_rd_en    = i_ena & ~i_wen & w_in_win & w_mask_ok;
  assign w_sign     = (i_sel == SEL_SEXT);

  // Lanes shifted past byte 7 fall off the 8-bit vector: misaligned stores never wrap
  assign w_lanes    = width_lanes(i_mask) << w_byte;
  assign w_wdata_sh = i_wdata << w_shamt;

  // Read sees the pre-edge contents, so a same-cycle write shows up next cycle
  assign w_word_sh  = r_mem[w_idx] >> w_shamt;

  // Byte-lane write of the shifted store data
  // NOTE: the array has no reset branch on purpose; clearing 1024 words needs
  // a sequencer, and software never relies on memory being wiped by reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (w_lanes[b]) begin
          r_mem[w_idx][b*8 +: 8] <= w_wdata_sh[b*8 +: 8];
        end
      end
    end
  end

  // Truncate to the access width and zero/sign-extend
  // NOTE: w_rd_ext gets a default before the case so no latch is inferred
  // for mask values that hit no arm.
  always_comb begin
    w_rd_ext = '0;
    case (i_mask)
      MASK_BYTE:  w_rd_ext = {{56{w_sign & w_word_sh[7]}},  w_word_sh[7:0]};
      MASK_HALF:  w_rd_ext = {{48{w_sign & w_word_sh[15]}}, w_word_sh[15:0]};
      MASK_WORD:  w_rd_ext = {{32{w_sign & w_word_sh[31]}}, w_word_sh[31:0]};
      MASK_DWORD: w_rd_ext = w_word_sh;
      default:    w_rd_ext = '0;
    endcase
  end

  assign o_rdata = w_rd_en ? w_rd_ext : '0;

endmodule

// File: rtl/id_ex_mem_regs.sv
// IF/ID and ID/EX pipeline registers plus the data-memory array used by MEM.
module id_ex_mem_regs
  import id_ex_mem_regs_pkg::*;
(
  input  logic                clk,
  input  logic                rst,

  input  logic                id_ena,
  input  logic                id_valid,
  input  logic                id_flush,
  input  logic [XLEN-1:0]     if_pc,
  input  logic [ILEN-1:0]     if_inst,
  input  logic                if_jump,
  output logic [XLEN-1:0]     id_pc,
  output logic [ILEN-1:0]     id_inst,
  output logic                id_jump,

  input  logic                ex_ena,
  input  logic                ex_valid,
  input  logic [XLEN-1:0]     dec_pc,
  input  logic [ILEN-1:0]     dec_inst,
  input  logic [ALU_OP_W-1:0] dec_alu_op,
  input  logic [3:0]          dec_sel_alures,
  input  logic [XLEN-1:0]     dec_alu_src1,
  input  logic [XLEN-1:0]     dec_alu_src2,
  input  logic [1:0]          dec_sel_rfres,
  input  logic                dec_rf_we,
  input  logic [4:0]          dec_rf_waddr,
  input  logic [XLEN-1:0]     dec_rf_rdata2,
  input  logic                dec_mem_ena,
  input  logic                dec_mem_wen,
  input  logic [3:0]          dec_mem_mask,
  input  logic [1:0]          dec_sel_memdata,
  input  logic                dec_load,
  input  logic                dec_sys,
  output logic [XLEN-1:0]     ex_pc,
  output logic [ILEN-1:0]     ex_inst,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic [3:0]          ex_sel_alures,
  output logic [XLEN-1:0]     ex_alu_src1,
  output logic [XLEN-1:0]     ex_alu_src2,
  output logic [1:0]          ex_sel_rfres,
  output logic                ex_rf_we,
  output logic [4:0]          ex_rf_waddr,
  output logic [XLEN-1:0]     ex_rf_rdata2,
  output logic                ex_mem_ena,
  output logic                ex_mem_wen,
  output logic [3:0]          ex_mem_mask,
  output logic [1:0]          ex_sel_memdata,
  output logic                ex_load,
  output logic                ex_sys,

  input  logic                mem_ena,
  input  logic                mem_wen,
  input  logic [3:0]          mem_mask,
  input  logic [1:0]          mem_sel_memdata,
  input  logic [XLEN-1:0]     mem_addr,
  input  logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN-1:0]     mem_rdata
);

  logic [XLEN-1:0] r_id_pc;
  logic [ILEN-1:0] r_id_inst;
  logic            r_id_jump;
  ex_bundle_t      r_ex;
  ex_bundle_t      w_dec;

  // IF/ID register: reset > flush > hold > bubble > load
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst || id_flush) begin
      r_id_pc   <= '0;
      r_id_inst <= NOP;
      r_id_jump <= 1'b0;
    end else if (id_ena) begin
      if (!id_valid) begin
        r_id_pc   <= '0;
        r_id_inst <= NOP;
        r_id_jump <= 1'b0;
      end else begin
        r_id_pc   <= if_pc;
        r_id_inst <= if_inst;
        r_id_jump <= if_jump;
      end
    end
  end

  assign id_pc   = r_id_pc;
  assign id_inst = r_id_inst;
  assign id_jump = r_id_jump;

  // Gather the decode-stage inputs into one bundle
  always_comb begin
    w_dec             = '0;
    w_dec.pc          = dec_pc;
    w_dec.inst        = dec_inst;
    w_dec.alu_op      = dec_alu_op;
    w_dec.sel_alures  = dec_sel_alures;
    w_dec.alu_src1    = dec_alu_src1;
    w_dec.alu_src2    = dec_alu_src2;
    w_dec.sel_rfres   = dec_sel_rfres;
    w_dec.rf_we       = dec_rf_we;
    w_dec.rf_waddr    = dec_rf_waddr;
    w_dec.rf_rdata2   = dec_rf_rdata2;
    w_dec.mem_ena     = dec_mem_ena;
    w_dec.mem_wen     = dec_mem_wen;
    w_dec.mem_mask    = dec_mem_mask;
    w_dec.sel_memdata = dec_sel_memdata;
    w_dec.load        = dec_load;
    w_dec.sys         = dec_sys;
  end

  // ID/EX register: reset > hold > bubble > load
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ex <= ex_bubble();
    end else if (ex_ena) begin
      r_ex <= ex_valid ? w_dec : ex_bubble();
    end
  end

  assign ex_pc          = r_ex.pc;
  assign ex_inst        = r_ex.inst;
  assign ex_alu_op      = r_ex.alu_op;
  assign ex_sel_alures  = r_ex.sel_alures;
  assign ex_alu_src1    = r_ex.alu_src1;
  assign ex_alu_src2    = r_ex.alu_src2;
  assign ex_sel_rfres   = r_ex.sel_rfres;
  assign ex_rf_we       = r_ex.rf_we;
  assign ex_rf_waddr    = r_ex.rf_waddr;
  assign ex_rf_rdata2   = r_ex.rf_rdata2;
  assign ex_mem_ena     = r_ex.mem_ena;
  assign ex_mem_wen     = r_ex.mem_wen;
  assign ex_mem_mask    = r_ex.mem_mask;
  assign ex_sel_memdata = r_ex.sel_memdata;
  assign ex_load        = r_ex.load;
  assign ex_sys         = r_ex.sys;

  dmem_array u_dmem (
    .clk     (clk),
    .i_ena   (mem_ena),
    .i_wen   (mem_wen),
    .i_mask  (mem_mask),
    .i_sel   (mem_sel_memdata),
    .i_addr  (mem_addr),
    .i_wdata (mem_wdata),
    .o_rdata (mem_rdata)
  );

endmodule

// File: tb/tb_id_ex_mem_regs.sv
// Directed bench for the IF/ID, ID/EX registers and the data memory.
module tb_id_ex_mem_regs;
  import id_ex_mem_regs_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                id_ena, id_valid, id_flush;
  logic [XLEN-1:0]     if_pc;
  logic [ILEN-1:0]     if_inst;
  logic                if_jump;
  logic [XLEN-1:0]     id_pc;
  logic [ILEN-1:0]     id_inst;
  logic                id_jump;
  logic                ex_ena, ex_valid;
  logic [XLEN-1:0]     dec_pc, dec_alu_src1, dec_alu_src2, dec_rf_rdata2;
  logic [ILEN-1:0]     dec_inst;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic [3:0]          dec_sel_alures, dec_mem_mask;
  logic [1:0]          dec_sel_rfres, dec_sel_memdata;
  logic                dec_rf_we, dec_mem_ena, dec_mem_wen, dec_load, dec_sys;
  logic [4:0]          dec_rf_waddr;
  logic [XLEN-1:0]     ex_pc, ex_alu_src1, ex_alu_src2, ex_rf_rdata2;
  logic [ILEN-1:0]     ex_inst;
  logic [ALU_OP_W-1:0] ex_alu_op;
  logic [3:0]          ex_sel_alures, ex_mem_mask;
  logic [1:0]          ex_sel_rfres, ex_sel_memdata;
  logic                ex_rf_we, ex_mem_ena, ex_mem_wen, ex_load, ex_sys;
  logic [4:0]          ex_rf_waddr;
  logic                mem_ena, mem_wen;
  logic [3:0]          mem_mask;
  logic [1:0]          mem_sel_memdata;
  logic [XLEN-1:0]     mem_addr, mem_wdata, mem_rdata;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  id_ex_mem_regs dut (
    .clk(clk), .rst(rst),
    .id_ena(id_ena), .id_valid(id_valid), .id_flush(id_flush),
    .if_pc(if_pc), .if_inst(if_inst), .if_jump(if_jump),
    .id_pc(id_pc), .id_inst(id_inst), .id_jump(id_jump),
    .ex_ena(ex_ena), .ex_valid(ex_valid),
    .dec_pc(dec_pc), .dec_inst(dec_inst), .dec_alu_op(dec_alu_op),
    .dec_sel_alures(dec_sel_alures), .dec_alu_src1(dec_alu_src1),
    .dec_alu_src2(dec_alu_src2), .dec_sel_rfres(dec_sel_rfres),
    .dec_rf_we(dec_rf_we), .dec_rf_waddr(dec_rf_waddr),
    .dec_rf_rdata2(dec_rf_rdata2), .dec_mem_ena(dec_mem_ena),
    .dec_mem_wen(dec_mem_wen), .dec_mem_mask(dec_mem_mask),
    .dec_sel_memdata(dec_sel_memdata), .dec_load(dec_load), .dec_sys(dec_sys),
    .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_alu_op(ex_alu_op),
    .ex_sel_alures(ex_sel_alures), .ex_alu_src1(ex_alu_src1),
    .ex_alu_src2(ex_alu_src2), .ex_sel_rfres(ex_sel_rfres),
    .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .ex_rf_rdata2(ex_rf_rdata2), .ex_mem_ena(ex_mem_ena),
    .ex_mem_wen(ex_mem_wen), .ex_mem_mask(ex_mem_mask),
    .ex_sel_memdata(ex_sel_memdata), .ex_load(ex_load), .ex_sys(ex_sys),
    .mem_ena(mem_ena), .mem_wen(mem_wen), .mem_mask(mem_mask),
    .mem_sel_memdata(mem_sel_memdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Advance one rising edge, then settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic [XLEN-1:0] pc, input logic [ILEN-1:0] inst,
                         input logic [ALU_OP_W-1:0] op, input logic [XLEN-1:0] s1,
                         input logic [XLEN-1:0] s2, input logic [4:0] waddr,
                         input logic ctl);
    dec_pc = pc; dec_inst = inst; dec_alu_op = op;
    dec_sel_alures = 4'h5; dec_alu_src1 = s1; dec_alu_src2 = s2;
    dec_sel_rfres = 2'b10; dec_rf_we = ctl; dec_rf_waddr = waddr;
    dec_rf_rdata2 = s2 ^ 64'hFFFF; dec_mem_ena = ctl; dec_mem_wen = ctl;
    dec_mem_mask = MASK_WORD; dec_sel_memdata = 2'b01; dec_load = ctl; dec_sys = ctl;
  endtask

  task automatic mem_write(input logic [XLEN-1:0] addr, input logic [XLEN-1:0] data,
                           input logic [3:0] mask);
    mem_addr = addr; mem_wdata = data; mem_mask = mask;
    mem_ena = 1'b1; mem_wen = 1'b1;
    tick();
    mem_ena = 1'b0; mem_wen = 1'b0;
  endtask

  task automatic mem_read(input logic [XLEN-1:0] addr, input logic [3:0] mask,
                          input logic [1:0] sel, output logic [XLEN-1:0] data);
    mem_addr = addr; mem_mask = mask; mem_sel_memdata = sel;
    mem_ena = 1'b1; mem_wen = 1'b0;
    #1;
    data = mem_rdata;
    mem_ena = 1'b0;
  endtask

  task automatic test_reset();
    // Busy inputs during reset: reset must override all of them
    rst = 1'b0; id_ena = 1'b1; id_valid = 1'b1; id_flush = 1'b0;
    if_pc = 64'h1234; if_inst = 32'hDEAD_BEEF; if_jump = 1'b1;
    ex_ena = 1'b1; ex_valid = 1'b1;
    set_dec(64'h5555, 32'hCAFE_F00D, 17'h1_0001, 64'h1, 64'h2, 5'd7, 1'b1);
    mem_ena = 1'b0; mem_wen = 1'b0; mem_mask = MASK_BYTE; mem_sel_memdata = SEL_ZEXT;
    mem_addr = DMEM_BASE; mem_wdata = '0;
    tick();
    n_total++; if (id_inst !== 32'h13) $display("FAIL rst_id_inst got %h exp %h", id_inst, 32'h13); else n_pass++;
    n_total++; if (id_pc !== 64'h0) $display("FAIL rst_id_pc got %h exp 0", id_pc); else n_pass++;
    n_total++; if (id_jump !== 1'b0) $display("FAIL rst_id_jump got %b exp 0", id_jump); else n_pass++;
    n_total++; if (ex_inst !== 32'h13) $display("FAIL rst_ex_inst got %h exp %h", ex_inst, 32'h13); else n_pass++;
    n_total++; if (ex_rf_we !== 1'b0) $display("FAIL rst_ex_rf_we got %b exp 0", ex_rf_we); else n_pass++;
    n_total++; if ({ex_mem_ena, ex_mem_wen, ex_load, ex_sys} !== 4'b0) $display("FAIL rst_ex_ctl got %b exp 0000", {ex_mem_ena, ex_mem_wen, ex_load, ex_sys}); else n_pass++;
    n_total++; if (ex_pc !== 64'h0 || ex_alu_src1 !== 64'h0) $display("FAIL rst_ex_data got pc=%h s1=%h exp 0", ex_pc, ex_alu_src1); else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_if_id();
    if_pc = 64'h8000_0004; if_inst = 32'h0010_0093; if_jump = 1'b1;
    id_ena = 1'b1; id_valid = 1'b1; id_flush = 1'b0;
    tick();
    n_total++; if (id_pc !== 64'h8000_0004) $display("FAIL ifid_load_pc got %h exp %h", id_pc, 64'h8000_0004); else n_pass++;
    n_total++; if (id_inst !== 32'h0010_0093) $display("FAIL ifid_load_inst got %h exp %h", id_inst, 32'h0010_0093); else n_pass++;
    n_total++; if (id_jump !== 1'b1) $display("FAIL ifid_load_jump got %b exp 1", id_jump); else n_pass++;
    // Hold
    id_ena = 1'b0; if_pc = 64'h8000_0008; if_inst = 32'h0020_0113; if_jump = 1'b0;
    tick();
    n_total++; if (id_pc !== 64'h8000_0004 || id_inst !== 32'h0010_0093) $display("FAIL ifid_hold got pc=%h inst=%h exp 80000004/00100093", id_pc, id_inst); else n_pass++;
    // Bubble
    id_ena = 1'b1; id_valid = 1'b0;
    tick();
    n_total++; if (id_pc !== 64'h0 || id_inst !== 32'h13 || id_jump !== 1'b0) $display("FAIL ifid_bubble got pc=%h inst=%h j=%b exp 0/13/0", id_pc, id_inst, id_jump); else n_pass++;
    // Reload, then flush while hold is also requested: flush wins
    id_valid = 1'b1; if_pc = 64'h8000_0004; if_inst = 32'h0010_0093; if_jump = 1'b1;
    tick();
    id_flush = 1'b1; id_ena = 1'b0;
    tick();
    n_total++; if (id_pc !== 64'h0 || id_inst !== 32'h13 || id_jump !== 1'b0) $display("FAIL ifid_flush got pc=%h inst=%h j=%b exp 0/13/0", id_pc, id_inst, id_jump); else n_pass++;
    id_flush = 1'b0; id_ena = 1'b1;
  endtask

  task automatic test_id_ex();
    ex_ena = 1'b1; ex_valid = 1'b1;
    set_dec(64'h8000_0010, 32'h0062_8233, 17'h1_2345, 64'hAAAA_0000_0000_0001,
            64'h0000_BBBB_0000_0002, 5'd17, 1'b1);
    tick();
    n_total++; if (ex_pc !== 64'h8000_0010 || ex_inst !== 32'h0062_8233) $display("FAIL idex_load_pc_inst got %h/%h exp 80000010/00628233", ex_pc, ex_inst); else n_pass++;
    n_total++; if (ex_alu_op !== 17'h1_2345 || ex_sel_alures !== 4'h5) $display("FAIL idex_load_alu got %h/%h exp 12345/5", ex_alu_op, ex_sel_alures); else n_pass++;
    n_total++; if (ex_alu_src1 !== 64'hAAAA_0000_0000_0001 || ex_alu_src2 !== 64'h0000_BBBB_0000_0002) $display("FAIL idex_load_src got %h/%h", ex_alu_src1, ex_alu_src2); else n_pass++;
    n_total++; if (ex_rf_waddr !== 5'd17 || ex_rf_rdata2 !== 64'h0000_BBBB_0000_FFFD || ex_sel_rfres !== 2'b10) $display("FAIL idex_load_rf got %h/%h/%b", ex_rf_waddr, ex_rf_rdata2, ex_sel_rfres); else n_pass++;
    n_total++; if ({ex_rf_we, ex_mem_ena, ex_mem_wen, ex_load, ex_sys} !== 5'b11111 || ex_mem_mask !== MASK_WORD || ex_sel_memdata !== 2'b01) $display("FAIL idex_load_ctl got %b/%b/%b", {ex_rf_we, ex_mem_ena, ex_mem_wen, ex_load, ex_sys}, ex_mem_mask, ex_sel_memdata); else n_pass++;
    // Hold while dec_* changes
    ex_ena = 1'b0;
    set_dec(64'h8000_0020, 32'h0000_0073, 17'h0_0001, 64'h3, 64'h4, 5'd2, 1'b0);
    tick();
    n_total++; if (ex_pc !== 64'h8000_0010 || ex_alu_src1 !== 64'hAAAA_0000_0000_0001 || ex_rf_we !== 1'b1) $display("FAIL idex_hold got pc=%h s1=%h we=%b", ex_pc, ex_alu_src1, ex_rf_we); else n_pass++;
    // Bubble with a store pending on the inputs
    ex_ena = 1'b1; ex_valid = 1'b0;
    set_dec(64'h8000_0030, 32'h00A5_3023, 17'h0_00FF, 64'h5, 64'h6, 5'd9, 1'b1);
    tick();
    n_total++; if (ex_mem_wen !== 1'b0 || ex_inst !== 32'h13 || ex_pc !== 64'h0) $display("FAIL idex_bubble got wen=%b inst=%h pc=%h exp 0/13/0", ex_mem_wen, ex_inst, ex_pc); else n_pass++;
    n_total++; if ({ex_rf_we, ex_mem_ena, ex_load, ex_sys} !== 4'b0 || ex_alu_op !== '0 || ex_alu_src2 !== '0 || ex_rf_waddr !== 5'd0) $display("FAIL idex_bubble_rest got ctl=%b op=%h s2=%h wa=%h", {ex_rf_we, ex_mem_ena, ex_load, ex_sys}, ex_alu_op, ex_alu_src2, ex_rf_waddr); else n_pass++;
  endtask

  task automatic test_back_to_back();
    ex_ena = 1'b1; ex_valid = 1'b1;
    set_dec(64'h8000_0100, 32'h1111_1111, 17'h0_0011, 64'h11, 64'h12, 5'd1, 1'b0);
    tick();
    n_total++; if (ex_pc !== 64'h8000_0100 || ex_alu_src1 !== 64'h11 || ex_rf_we !== 1'b0) $display("FAIL b2b_first got pc=%h s1=%h we=%b", ex_pc, ex_alu_src1, ex_rf_we); else n_pass++;
    set_dec(64'h8000_0104, 32'h2222_2222, 17'h0_0022, 64'h21, 64'h22, 5'd2, 1'b1);
    tick();
    n_total++; if (ex_pc !== 64'h8000_0104 || ex_inst !== 32'h2222_2222 || ex_rf_we !== 1'b1) $display("FAIL b2b_second got pc=%h inst=%h we=%b", ex_pc, ex_inst, ex_rf_we); else n_pass++;
    // Mid-stream reset overrides enabled loads on both registers
    rst = 1'b0; id_valid = 1'b1; id_ena = 1'b1; if_pc = 64'h8000_0200;
    tick();
    n_total++; if (ex_inst !== 32'h13 || ex_rf_we !== 1'b0 || id_pc !== 64'h0) $display("FAIL midstream_rst got ex_inst=%h we=%b id_pc=%h", ex_inst, ex_rf_we, id_pc); else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_mem_extend();
    logic [XLEN-1:0] d;
    mem_write(64'h8000_0000, 64'h1122_3344_5566_8899, MASK_DWORD);
    mem_read(64'h8000_0000, MASK_BYTE, SEL_SEXT, d);
    n_total++; if (d !== 64'hFFFF_FFFF_FFFF_FF99) $display("FAIL lb_sext got %h exp ffffffffffffff99", d); else n_pass++;
    mem_read(64'h8000_0000, MASK_BYTE, SEL_ZEXT, d);
    n_total++; if (d !== 64'h99) $display("FAIL lbu got %h exp 99", d); else n_pass++;
    mem_read(64'h8000_0000, MASK_BYTE, 2'b10, d);
    n_total++; if (d !== 64'h99) $display("FAIL lb_reserved_sel got %h exp 99", d); else n_pass++;
    mem_read(64'h8000_0001, MASK_BYTE, SEL_SEXT, d);
    n_total++; if (d !== 64'hFFFF_FFFF_FFFF_FF88) $display("FAIL lb_off1 got %h exp ffffffffffffff88", d); else n_pass++;
    mem_read(64'h8000_0002, MASK_HALF, SEL_SEXT, d);
    n_total++; if (d !== 64'h5566) $display("FAIL lh_off2 got %h exp 5566", d); else n_pass++;
    mem_read(64'h8000_0000, MASK_WORD, SEL_SEXT, d);
    n_total++; if (d !== 64'h0000_0000_5566_8899) $display("FAIL lw_off0 got %h exp 55668899", d); else n_pass++;
    mem_read(64'h8000_0004, MASK_WORD, SEL_SEXT, d);
    n_total++; if (d !== 64'h1122_3344) $display("FAIL lw_off4 got %h exp 11223344", d); else n_pass++;
    mem_read(64'h8000_0000, MASK_DWORD, SEL_ZEXT, d);
    n_total++; if (d !== 64'h1122_3344_5566_8899) $display("FAIL ld got %h exp 1122334455668899", d); else n_pass++;
  endtask

  task automatic test_mem_partial();
    logic [XLEN-1:0] d;
    mem_write(64'h8000_0008, 64'h0102_0304_0506_0708, MASK_DWORD);
    mem_write(64'h8000_0006, 64'h0000_0000_0000_ABCD, MASK_HALF);
    mem_read(64'h8000_0000, MASK_DWORD, SEL_ZEXT, d);
    n_total++; if (d !== 64'hABCD_3344_5566_8899) $display("FAIL sh_off6 got %h exp abcd334455668899", d); else n_pass++;
    mem_write(64'h8000_0006, 64'h0000_0000_DEAD_BEEF, MASK_WORD);
    mem_read(64'h8000_0000, MASK_DWORD, SEL_ZEXT, d);
    n_total++; if (d !== 64'hBEEF_3344_5566_8899) $display("FAIL sw_misaligned got %h exp beef334455668899", d); else n_pass++;
    mem_read(64'h8000_0008, MASK_DWORD, SEL_ZEXT, d);
    n_total++; if (d !== 64'h0102_0304_0506_0708) $display("FAIL sw_no_wrap got %h exp 0102030405060708", d); else n_pass++;
    mem_read(64'h8000_0006, MASK_WORD, SEL_SEXT, d);
    n_total++; if (d !== 64'hBEEF) $display("FAIL lw_misaligned got %h exp beef", d); else n_pass++;
    // Write enable without access enable must not store
    mem_addr = 64'h8000_0008; mem_wdata = 64'hFFFF_FFFF_FFFF_FFFF; mem_mask = MASK_DWORD;
    mem_ena = 1'b0; mem_wen = 1'b1;
    tick();
    n_total++; if (mem_rdata !== 64'h0) $display("FAIL rdata_ena0 got %h exp 0", mem_rdata); else n_pass++;
    mem_ena = 1'b1;
    #1;
    n_total++; if (mem_rdata !== 64'h0) $display("FAIL rdata_wen1 got %h exp 0", mem_rdata); else n_pass++;
    mem_wen = 1'b0;
    mem_read(64'h8000_0008, MASK_DWORD, SEL_ZEXT, d);
    n_total++; if (d !== 64'h0102_0304_0506_0708) $display("FAIL no_write_ena0 got %h exp 0102030405060708", d); else n_pass++;
    mem_read(64'h8000_0008, 4'b0011, SEL_ZEXT, d);
    n_total++; if (d !== 64'h0) $display("FAIL bad_mask_read got %h exp 0", d); else n_pass++;
    mem_write(64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000);
    mem_read(64'h8000_0008, MASK_DWORD, SEL_ZEXT, d);
    n_total++; if (d !== 64'h0102_0304_0506_0708) $display("FAIL bad_mask_write got %h exp 0102030405060708", d); else n_pass++;
  endtask

  task automatic test_mem_window();
    logic [XLEN-1:0] d;
    mem_write(64'h8000_1FF8, 64'h0F0E_0D0C_0B0A_0908, MASK_DWORD);
    mem_read(64'h8000_1FF8, MASK_DWORD, SEL_ZEXT, d);
    n_total++; if (d !== 64'h0F0E_0D0C_0B0A_0908) $display("FAIL last_word got %h exp 0f0e0d0c0b0a0908", d); else n_pass++;
    // Below base aliases index 1023, one past the end aliases index 0
    mem_write(64'h7FFF_FFF8, 64'hAAAA_AAAA_AAAA_AAAA, MASK_DWORD);
    mem_write(64'h8000_2000, 64'h5555_5555_5555_5555, MASK_DWORD);
    mem_read(64'h7FFF_FFF8, MASK_DWORD, SEL_ZEXT, d);
    n_total++; if (d !== 64'h0) $display("FAIL below_base_read got %h exp 0", d); else n_pass++;
    mem_read(64'h8000_2000, MASK_DWORD, SEL_ZEXT, d);
    n_total++; if (d !== 64'h0) $display("FAIL above_top_read got %h exp 0", d); else n_pass++;
    mem_read(64'h8000_1FF8, MASK_DWORD, SEL_ZEXT, d);
    n_total++; if (d !== 64'h0F0E_0D0C_0B0A_0908) $display("FAIL below_base_no_write got %h exp 0f0e0d0c0b0a0908", d); else n_pass++;
    mem_read(64'h8000_0000, MASK_DWORD, SEL_ZEXT, d);
    n_total++; if (d !== 64'hBEEF_3344_5566_8899) $display("FAIL above_top_no_write got %h exp beef334455668899", d); else n_pass++;
    // Reset leaves memory contents intact
    rst = 1'b0;
    tick();
    rst = 1'b1;
    mem_read(64'h8000_0000, MASK_DWORD, SEL_ZEXT, d);
    n_total++; if (d !== 64'hBEEF_3344_5566_8899) $display("FAIL mem_survives_rst got %h exp beef334455668899", d); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_if_id();
    test_id_ex();
    test_back_to_back();
    test_mem_extend();
    test_mem_partial();
    test_mem_window();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
